// File: rtl/nl2_dbank_pkg.sv
// Types and helpers shared by the data-bank read and write controllers.
// Struct fields are sized for the largest bank configuration and narrowed at use.
package nl2_dbank_pkg;

    localparam int DBANK_MAX_SRAM = 4;
    localparam int DBANK_MAX_ID   = 8;
    localparam int DBANK_MAX_IL   = 8;

    typedef enum logic {
        S_RCTL_IDLE,
        S_RCTL_BUSY
    } dbank_rctl_state_e;

    typedef struct packed {
        logic [DBANK_MAX_SRAM-1:0] sram;
        logic                      last;
        logic [DBANK_MAX_ID-1:0]   id;
        logic                      err;
    } dbank_fifo_ent_t;

    // Advance to the next beat-aligned address; bits under the wrap mask roll over.
    function automatic logic [DBANK_MAX_IL-1:0] dbank_step(
        input logic [DBANK_MAX_IL-1:0] a,
        input logic [DBANK_MAX_IL-1:0] mask,
        input logic [2:0]              dsize
    );
        logic [DBANK_MAX_IL-1:0] inc;
        logic [DBANK_MAX_IL-1:0] align;
        inc   = DBANK_MAX_IL'(1) << dsize;
        align = ~(inc - DBANK_MAX_IL'(1));
        return (~mask & a) | (mask & ((a + inc) & align));
    endfunction

    function automatic logic [15:0] dbank_sram_sel(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/nl2_cln_fifo.sv
// Small first-word-fall-through FIFO; the head entry is visible while not empty.
module nl2_cln_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/nl2_dbank_rd_ctrl.sv
// Data-bank read controller: splits a burst into per-SRAM beats and returns
// responses in order as each SRAM's read data is captured.
module nl2_dbank_rd_ctrl
    import nl2_dbank_pkg::*;
#(
    parameter int N_SRAM         = 4,
    parameter int BNK_ADDR_SIZE  = 10,
    parameter int CMD_ID_SIZE    = 1,
    parameter int BNK_DATA_WIDTH = 64,
    parameter int INTERLEAVE_ADR = 5,
    parameter int SRAM_SEL_MSB   = 4,
    parameter int SRAM_SEL_LSB   = 3
) (
    input  logic                                       dbank_ctrl_clk,
    input  logic                                       rst_a_n,
    input  logic                                       do_rd,
    input  logic [BNK_ADDR_SIZE-1:0]                   cmd_addr,
    input  logic [CMD_ID_SIZE-1:0]                     cmd_id,
    input  logic                                       cmd_err,
    input  logic                                       wrap,
    input  logic [3:0]                                 burst_size,
    input  logic [2:0]                                 data_size,
    input  logic                                       init_going,
    input  logic [N_SRAM-1:0]                          dbank_active_next,
    input  logic [N_SRAM-1:0]                          capture_dbank_next,
    input  logic                                       rd_stall,
    output logic [N_SRAM-1:0]                          bnk_rd_en,
    output logic [BNK_ADDR_SIZE-$clog2(N_SRAM)-7:0]    bnk_rd_block_addr,
    output logic                                       rd_done,
    output logic                                       rd_rsp_valid,
    output logic [N_SRAM-1:0]                          rd_rsp_sram_sel,
    output logic                                       rd_rsp_last,
    output logic [CMD_ID_SIZE-1:0]                     rd_rsp_id,
    output logic                                       rd_rsp_err,
    output logic                                       rd_idle
);
    localparam int SRAM_W = $clog2(N_SRAM);
    localparam int LO_W   = INTERLEAVE_ADR - SRAM_W - 3;
    localparam int FIFO_W = N_SRAM + 2 + CMD_ID_SIZE;

    dbank_rctl_state_e         state_q, state_d;
    logic [INTERLEAVE_ADR-1:0] addr_lo_q, addr_lo_d;
    logic [INTERLEAVE_ADR-1:0] wrap_mask_q, wrap_mask_d;
    logic [3:0]                burst_cnt_q, burst_cnt_d;

    logic [INTERLEAVE_ADR-1:0] addr_cur, wrap_mask_new, mask_cur;
    logic [15:0]               wm_full, sel_full;
    logic [DBANK_MAX_IL-1:0]   step_full;
    logic [N_SRAM-1:0]         target;
    logic                      can_issue;
    logic                      fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [FIFO_W-1:0]         fifo_din, fifo_dout;
    logic [N_SRAM-1:0]         head_sram;
    dbank_fifo_ent_t           push_ent;

    assign addr_cur      = (state_q == S_RCTL_IDLE) ? cmd_addr[INTERLEAVE_ADR-1:0] : addr_lo_q;
    assign wm_full       = ((16'(burst_size) + 16'd1) << data_size) - 16'd1;
    assign wrap_mask_new = wrap ? wm_full[INTERLEAVE_ADR-1:0] : '1;
    assign mask_cur      = (state_q == S_RCTL_IDLE) ? wrap_mask_new : wrap_mask_q;
    assign step_full     = dbank_step(DBANK_MAX_IL'(addr_cur), DBANK_MAX_IL'(mask_cur), data_size);
    assign sel_full      = dbank_sram_sel(4'(addr_cur[SRAM_SEL_MSB:SRAM_SEL_LSB]));
    assign target        = sel_full[N_SRAM-1:0];
    assign can_issue     = (|(target & dbank_active_next)) && !rd_stall && !init_going && !fifo_full;

    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        wrap_mask_d = wrap_mask_q;
        burst_cnt_d = burst_cnt_q;
        bnk_rd_en   = '0;
        rd_done     = 1'b0;
        fifo_push   = 1'b0;
        push_ent    = '0;
        push_ent.id[CMD_ID_SIZE-1:0] = cmd_id;
        case (state_q)
            S_RCTL_IDLE: begin
                if (do_rd) begin
                    if (cmd_err) begin
                        // Errored commands bypass the SRAMs and only need a response slot.
                        if (!fifo_full) begin
                            fifo_push     = 1'b1;
                            push_ent.last = 1'b1;
                            push_ent.err  = 1'b1;
                            rd_done       = 1'b1;
                        end
                    end else if (can_issue) begin
                        bnk_rd_en                   = target;
                        fifo_push                   = 1'b1;
                        push_ent.sram[N_SRAM-1:0]   = target;
                        if (burst_size == 4'd0) begin
                            rd_done       = 1'b1;
                            push_ent.last = 1'b1;
                        end else begin
                            burst_cnt_d = burst_size - 4'd1;
                            addr_lo_d   = step_full[INTERLEAVE_ADR-1:0];
                            wrap_mask_d = wrap_mask_new;
                            state_d     = S_RCTL_BUSY;
                        end
                    end else begin
                        addr_lo_d   = cmd_addr[INTERLEAVE_ADR-1:0];
                        burst_cnt_d = burst_size;
                        wrap_mask_d = wrap_mask_new;
                        state_d     = S_RCTL_BUSY;
                    end
                end
            end
            S_RCTL_BUSY: begin
                if (can_issue) begin
                    bnk_rd_en                 = target;
                    fifo_push                 = 1'b1;
                    push_ent.sram[N_SRAM-1:0] = target;
                    if (burst_cnt_q == 4'd0) begin
                        rd_done       = 1'b1;
                        push_ent.last = 1'b1;
                        state_d       = S_RCTL_IDLE;
                    end else begin
                        burst_cnt_d = burst_cnt_q - 4'd1;
                        addr_lo_d   = step_full[INTERLEAVE_ADR-1:0];
                    end
                end
            end
            default: state_d = S_RCTL_IDLE;
        endcase
    end

    always_ff @(posedge dbank_ctrl_clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q     <= S_RCTL_IDLE;
            addr_lo_q   <= '0;
            wrap_mask_q <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            wrap_mask_q <= wrap_mask_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    generate
        if (LO_W > 0) begin : g_blk_lo
            assign bnk_rd_block_addr = {cmd_addr[BNK_ADDR_SIZE-1:INTERLEAVE_ADR+3],
                                        addr_cur[INTERLEAVE_ADR-1:SRAM_W+3]};
        end else begin : g_blk_hi
            assign bnk_rd_block_addr = cmd_addr[BNK_ADDR_SIZE-1:INTERLEAVE_ADR+3];
        end
    endgenerate

    assign fifo_din = {push_ent.sram[N_SRAM-1:0], push_ent.last,
                       push_ent.id[CMD_ID_SIZE-1:0], push_ent.err};

    nl2_cln_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (N_SRAM)
    ) u_trk_fifo (
        .clk     (dbank_ctrl_clk),
        .rst_n   (rst_a_n),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // An entry with no SRAM (error response) retires without waiting for capture.
    assign head_sram       = fifo_dout[FIFO_W-1 -: N_SRAM];
    assign fifo_pop        = !fifo_empty && ((|(head_sram & capture_dbank_next)) || (head_sram == '0));
    assign rd_rsp_valid    = fifo_pop;
    assign rd_rsp_sram_sel = fifo_pop ? head_sram : '0;
    assign rd_rsp_last     = fifo_pop && fifo_dout[CMD_ID_SIZE+1];
    assign rd_rsp_id       = fifo_pop ? fifo_dout[CMD_ID_SIZE:1] : '0;
    assign rd_rsp_err      = fifo_pop && fifo_dout[0];
    assign rd_idle         = (state_q == S_RCTL_IDLE) && fifo_empty;

    logic unused_ok;
    assign unused_ok = ^{cmd_addr[INTERLEAVE_ADR+2:INTERLEAVE_ADR], wm_full, sel_full, step_full,
                         push_ent, BNK_DATA_WIDTH[0]};

endmodule

// File: tb/tb_nl2_dbank_rd_ctrl.sv
// Directed bench for the data-bank read controller with hand-computed beat and response orders.
module tb_nl2_dbank_rd_ctrl;

    logic       clk;
    logic       rst_a_n;
    logic       do_rd;
    logic [9:0] cmd_addr;
    logic [0:0] cmd_id;
    logic       cmd_err;
    logic       wrap;
    logic [3:0] burst_size;
    logic [2:0] data_size;
    logic       init_going;
    logic [3:0] dbank_active_next;
    logic [3:0] capture_dbank_next;
    logic       rd_stall;
    logic [3:0] bnk_rd_en;
    logic [1:0] bnk_rd_block_addr;
    logic       rd_done;
    logic       rd_rsp_valid;
    logic [3:0] rd_rsp_sram_sel;
    logic       rd_rsp_last;
    logic [0:0] rd_rsp_id;
    logic       rd_rsp_err;
    logic       rd_idle;

    nl2_dbank_rd_ctrl dut (
        .dbank_ctrl_clk     (clk),
        .rst_a_n            (rst_a_n),
        .do_rd              (do_rd),
        .cmd_addr           (cmd_addr),
        .cmd_id             (cmd_id),
        .cmd_err            (cmd_err),
        .wrap               (wrap),
        .burst_size         (burst_size),
        .data_size          (data_size),
        .init_going         (init_going),
        .dbank_active_next  (dbank_active_next),
        .capture_dbank_next (capture_dbank_next),
        .rd_stall           (rd_stall),
        .bnk_rd_en          (bnk_rd_en),
        .bnk_rd_block_addr  (bnk_rd_block_addr),
        .rd_done            (rd_done),
        .rd_rsp_valid       (rd_rsp_valid),
        .rd_rsp_sram_sel    (rd_rsp_sram_sel),
        .rd_rsp_last        (rd_rsp_last),
        .rd_rsp_id          (rd_rsp_id),
        .rd_rsp_err         (rd_rsp_err),
        .rd_idle            (rd_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] iss_en  [$];
    logic [1:0] iss_blk [$];
    int         iss_cyc [$];
    logic [6:0] rsp     [$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         stall_iss = 0;
    int         max_out = 0;

    // Observe the DUT on the falling edge, away from the launching edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_a_n) begin
                cyc++;
                if (|bnk_rd_en) begin
                    iss_en.push_back(bnk_rd_en);
                    iss_blk.push_back(bnk_rd_block_addr);
                    iss_cyc.push_back(cyc);
                    if (rd_stall) stall_iss++;
                end
                if (rd_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (rd_rsp_valid) rsp.push_back({rd_rsp_sram_sel, rd_rsp_last, rd_rsp_id, rd_rsp_err});
                if (iss_en.size() - rsp.size() > max_out) max_out = iss_en.size() - rsp.size();
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        iss_en.delete();
        iss_blk.delete();
        iss_cyc.delete();
        rsp.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        stall_iss = 0;
        max_out   = 0;
    endtask

    task automatic chk_iss(input string tag, input int n, input logic [31:0] seq, input logic [1:0] blk);
        chk({tag, "_nbeats"}, iss_en.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] g;
            logic [1:0] b;
            g = (i < iss_en.size()) ? iss_en[i] : 4'h0;
            b = (i < iss_blk.size()) ? iss_blk[i] : 2'bxx;
            chk($sformatf("%s_en%0d", tag, i), g, seq[4*i +: 4]);
            chk($sformatf("%s_blk%0d", tag, i), b, blk);
        end
    endtask

    task automatic chk_rsp(input string tag, input int n, input logic [31:0] seq, input logic id, input logic err);
        chk({tag, "_nrsp"}, rsp.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [6:0] g;
            logic [6:0] e;
            g = (i < rsp.size()) ? rsp[i] : 7'h7f;
            e = {seq[4*i +: 4], (i == n - 1), id, err};
            chk($sformatf("%s_rsp%0d", tag, i), g, e);
        end
    endtask

    // Call at posedge+1; holds the command until rd_done is seen.
    task automatic issue_cmd(input string tag, input logic [9:0] addr, input logic [3:0] bs,
                             input logic [2:0] ds, input logic wr, input logic id, input logic err);
        bit done = 1'b0;
        cmd_addr = addr; burst_size = bs; data_size = ds; wrap = wr;
        cmd_id = id; cmd_err = err; do_rd = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            #3;
            if (rd_done === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        do_rd = 1'b0;
        cmd_err = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        $display("[TB] %s addr=%h burst=%0d size=%0d wrap=%0d err=%0d beats=%0d", tag, addr, bs, ds, wr, err, iss_en.size());
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a_n = 1'b0; do_rd = 1'b0; cmd_addr = '0; cmd_id = '0; cmd_err = 1'b0;
        wrap = 1'b0; burst_size = '0; data_size = '0; init_going = 1'b0;
        dbank_active_next = 4'hF; capture_dbank_next = 4'hF; rd_stall = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_idle", rd_idle, 1);
        chk("rst_rsp_valid", rd_rsp_valid, 0);
        chk("rst_rd_en", bnk_rd_en, 0);
        chk("rst_done", rd_done, 0);
        @(posedge clk); #1;
        rst_a_n = 1'b1;
        drain(2);

        // Single beat at 0x08 -> SRAM1, done with the issue.
        clear_mon();
        issue_cmd("single", 10'h008, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0);
        drain(4);
        chk_iss("single", 1, 32'h2, 2'd0);
        chk("single_done_cyc", done_cyc, (iss_cyc.size() > 0) ? iss_cyc[0] : -2);
        chk_rsp("single", 1, 32'h2, 1'b0, 1'b0);
        chk("single_idle", rd_idle, 1);

        // Incrementing 4 beats from 0x100 -> SRAM 0,1,2,3 back to back.
        clear_mon();
        issue_cmd("incr", 10'h100, 4'd3, 3'd3, 1'b0, 1'b1, 1'b0);
        drain(4);
        chk_iss("incr", 4, 32'h8421, 2'd1);
        chk("incr_consec", (iss_cyc.size() > 3) ? iss_cyc[3] - iss_cyc[0] : -1, 3);
        chk_rsp("incr", 4, 32'h8421, 1'b1, 1'b0);

        // Wrapping 4 beats from 0x318 -> SRAM 3,0,1,2 (0x18,0x00,0x08,0x10).
        clear_mon();
        issue_cmd("wrap", 10'h318, 4'd3, 3'd3, 1'b1, 1'b0, 1'b0);
        drain(4);
        chk_iss("wrap", 4, 32'h4218, 2'd3);
        chk_rsp("wrap", 4, 32'h4218, 1'b0, 1'b0);

        // 7 beats with a stall window and capture withheld until the FIFO fills.
        clear_mon();
        capture_dbank_next = 4'h0;
        fork
            issue_cmd("bp", 10'h000, 4'd6, 3'd3, 1'b0, 1'b1, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 rd_stall = 1'b1;
                repeat (5) @(posedge clk);
                #1 rd_stall = 1'b0;
                repeat (8) @(posedge clk);
                #1 capture_dbank_next = 4'hF;
            end
        join
        drain(8);
        chk_iss("bp", 7, 32'h04218421, 2'd0);
        chk_rsp("bp", 7, 32'h04218421, 1'b1, 1'b0);
        chk("bp_stall_iss", stall_iss, 0);
        chk("bp_max_outstanding", max_out, 4);

        // Errored command: no SRAM read, one error response.
        clear_mon();
        issue_cmd("err", 10'h010, 4'd3, 3'd3, 1'b0, 1'b1, 1'b1);
        drain(4);
        chk("err_nbeats", iss_en.size(), 0);
        chk("err_ndone", done_cnt, 1);
        chk_rsp("err", 1, 32'h0, 1'b1, 1'b1);

        // Writer init in progress: command waits until init_going falls.
        clear_mon();
        init_going = 1'b1;
        fork
            issue_cmd("init", 10'h008, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #2;
                chk("init_nodone", done_cnt, 0);
                chk("init_noiss", iss_en.size(), 0);
                init_going = 1'b0;
            end
        join
        drain(4);
        chk_iss("init", 1, 32'h2, 2'd0);
        chk_rsp("init", 1, 32'h2, 1'b0, 1'b0);

        // Reset after 2 of 4 beats: outstanding beats vanish without response.
        clear_mon();
        capture_dbank_next = 4'h0;
        cmd_addr = 10'h000; burst_size = 4'd3; data_size = 3'd3; wrap = 1'b0; do_rd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a_n = 1'b0;
        do_rd = 1'b0;
        #2;
        chk("rstmid_rd_en", bnk_rd_en, 0);
        chk("rstmid_done", rd_done, 0);
        chk("rstmid_rsp_valid", rd_rsp_valid, 0);
        chk("rstmid_idle", rd_idle, 1);
        @(posedge clk); #1;
        rst_a_n = 1'b1;
        capture_dbank_next = 4'hF;
        drain(6);
        chk("rstmid_nbeats", iss_en.size(), 2);
        chk("rstmid_nrsp", rsp.size(), 0);
        chk("rstmid_idle_after", rd_idle, 1);
        $display("[TB] reset mid-burst beats=%0d rsp=%0d", iss_en.size(), rsp.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nl2_dbank_rd_ctrl.md
NL2_DBANK_RD_CTRL -- requirements
Module: nl2_dbank_rd_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N_SRAM, 4, sub-bank SRAMs (2 or 4); BNK_ADDR_SIZE, 10, bank byte-address width; CMD_ID_SIZE, 1, command id width; BNK_DATA_WIDTH, 64, SRAM word bits; INTERLEAVE_ADR, 5, log2 interleave bytes; SRAM_SEL_MSB, 4 and SRAM_SEL_LSB, 3, SRAM-select bit field in address.
REQ-002 Ports SHALL be (name direction width meaning): dbank_ctrl_clk in 1 clock; rst_a_n in 1 reset; do_rd in 1 read command present; cmd_addr in BNK_ADDR_SIZE byte address, stable until rd_done; cmd_id in CMD_ID_SIZE; cmd_err in 1 command error; wrap in 1; burst_size in 4 beats-1; data_size in 3 log2 bytes/beat; init_going in 1 writer init active; dbank_active_next in N_SRAM SRAM issue slot; capture_dbank_next in N_SRAM SRAM data-capture slot; rd_stall in 1 downstream full; bnk_rd_en out N_SRAM one-hot read enable; bnk_rd_block_addr out BNK_ADDR_SIZE-3-INTERLEAVE_ADR+INTERLEAVE_ADR-clog2(N_SRAM)-3 SRAM row; rd_done out 1 command consumed; rd_rsp_valid out 1; rd_rsp_sram_sel out N_SRAM data mux select; rd_rsp_last out 1; rd_rsp_id out CMD_ID_SIZE; rd_rsp_err out 1; rd_idle out 1.
REQ-003 The block SHALL use one clock, dbank_ctrl_clk; reset rst_a_n is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be S_RCTL_IDLE and S_RCTL_BUSY; state holds addr_lo[INTERLEAVE_ADR-1:0], wrap_mask, burst_cnt[3:0].
REQ-005 wrap_mask SHALL be ((burst_size+1)<<data_size)-1 truncated to INTERLEAVE_ADR when wrap=1, else all ones; computed in IDLE on do_rd.
REQ-006 Next address SHALL be (~wrap_mask & a) | (wrap_mask & ((a + 2^data_size) & ~(2^data_size-1))), bits above INTERLEAVE_ADR discarded (wrap-around inside interleave window).
REQ-007 Target SRAM SHALL be one-hot 1<<addr[SRAM_SEL_MSB:SRAM_SEL_LSB]; a beat issues only when target & dbank_active_next nonzero, !rd_stall, !init_going and tracking FIFO not full.
REQ-008 IDLE with do_rd, cmd_err=0: issue beat 0 same cycle from cmd_addr if REQ-007 holds; burst_size=0 -> rd_done=1, stay IDLE; else burst_cnt=burst_size-1, addr_lo=step, go BUSY; if blocked, load addr_lo=cmd_addr low bits, burst_cnt=burst_size, go BUSY.
REQ-009 BUSY: issue beat at addr_lo when REQ-007 holds; burst_cnt=0 -> rd_done=1, return IDLE; else decrement, step.
REQ-010 do_rd with cmd_err=1 SHALL issue no SRAM read: push one FIFO entry (sram=0, last=1, err=1), rd_done=1 same cycle, subject only to FIFO not full.
REQ-011 bnk_rd_block_addr SHALL be {cmd_addr[BNK_ADDR_SIZE-1:INTERLEAVE_ADR+3], current addr[INTERLEAVE_ADR-1:clog2(N_SRAM)+3]}; current addr = cmd_addr low bits in IDLE, addr_lo in BUSY.
REQ-012 Each issued beat SHALL push {bnk_rd_en, last, cmd_id, cmd_err} into a depth-N_SRAM FIFO; last=1 on the beat asserting rd_done.
REQ-013 FIFO pop SHALL occur when head valid and (head_sram & capture_dbank_next nonzero, or head_sram==0); rd_rsp_valid=pop, fields from head; latency issue->response is set by capture_dbank_next, in-order.
REQ-014 Simultaneous push and pop SHALL both take effect; full FIFO blocks issue (no loss), empty FIFO gives rd_rsp_valid=0.
REQ-015 rd_idle SHALL be 1 when FSM in IDLE and FIFO empty.
REQ-016 do_rd while init_going=1 SHALL wait (no issue, no rd_done) until init_going falls.

Reset
REQ-017 On rst_a_n=0, state SHALL be IDLE, addr_lo/wrap_mask/burst_cnt=0, FIFO empty; all outputs 0 except rd_idle=1; mid-burst reset discards outstanding beats with no response.

Structure
REQ-018 State enum, FIFO entry struct, step and sram_select functions SHALL live in shared package nl2_dbank_pkg, shared with the write controller.
REQ-019 The tracking FIFO SHALL be an instance of existing nl2_cln_fifo (WIDTH N_SRAM+2+CMD_ID_SIZE, DEPTH N_SRAM).

Verification
REQ-020 Single beat: addr 0x08, burst 0, size 3, slots always on -> bnk_rd_en=0010 cycle 0, rd_done cycle 0, rd_rsp_valid with last=1 on capture of SRAM1.
REQ-021 Incrementing: addr 0x00, burst 3, size 3 -> bnk_rd_en 0001,0010,0100,1000 consecutive cycles, last only on fourth response.
REQ-022 Wrap: addr 0x18, burst 3, size 3, wrap -> SRAM order 3,0,1,2, addresses 0x18,0x00,0x08,0x10.
REQ-023 Backpressure: rd_stall=1 for 5 cycles mid-burst, capture withheld until FIFO full -> no issue while stalled/full, no lost or duplicated responses.
REQ-024 Error and init: cmd_err=1 -> no bnk_rd_en, one response err=1 last=1; init_going=1 -> no rd_done until it falls.
REQ-025 Reset mid-burst after 2 of 4 beats -> all outputs 0, rd_idle=1 next cycle, no response.
